// File: rtl/instr_cache_dm.sv
// Direct-mapped read-only instruction cache. A hit returns the word one cycle after the address is
// sampled; a miss stalls fetch while the line is refilled one word per req/ack beat.
// Defining ICACHE_FLUSH_EN adds flush_i (fence.i) to invalidate every line.
module instr_cache_dm #(
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned NUM_LINES   = 64,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [30:2] addr_i,
  output logic [31:0] instr_o,
  output logic        blocking_n_o,
  output logic        mem_req_o,
  output logic [30:2] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
`ifdef ICACHE_FLUSH_EN
  ,
  input  logic        flush_i
`endif
);

  localparam int unsigned OFS_W  = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = 29 - OFS_W - IDX_W;
  localparam int unsigned IDX_LO = OFS_W + 2;
  localparam int unsigned TAG_LO = OFS_W + IDX_W + 2;
  localparam logic [OFS_W-1:0] LastWord = OFS_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {StLookup, StRefill, StWrite} state_e;

  state_e             state_q, state_d;
  logic [30:IDX_LO]   addr_q;                    // tag+index of the address being looked up
  logic [30:IDX_LO]   miss_line_q, miss_line_d;  // tag+index of the line being refilled
  logic               lookup_vld_q, lookup_vld_d;
  logic [OFS_W-1:0]   cnt_q, cnt_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic               flush_pend_q, flush_pend_d;

  logic [31:0]        data_mem [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0]   tag_mem  [NUM_LINES];
  logic [31:0]        data_rd_q;
  logic [TAG_W-1:0]   tag_rd_q;
  logic               data_we, tag_we;
  logic               hit;
  logic               flush;

`ifdef ICACHE_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign hit = (state_q == StLookup) && lookup_vld_q && valid_q[addr_q[TAG_LO-1:IDX_LO]] &&
               (tag_rd_q == addr_q[30:TAG_LO]);

  // Next-state, array write enables and outputs.
  always_comb begin
    state_d      = state_q;
    miss_line_d  = miss_line_q;
    lookup_vld_d = 1'b0;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    blocking_n_o = 1'b0;
    instr_o      = RESET_INSTR;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    case (state_q)
      StLookup: begin
        // A flush makes the next cycle a fresh lookup rather than a compare.
        lookup_vld_d = !flush;
        if (hit) begin
          blocking_n_o = 1'b1;
          instr_o      = data_rd_q;
        end else if (lookup_vld_q) begin
          miss_line_d  = addr_q;
          cnt_d        = '0;
          lookup_vld_d = 1'b0;
          state_d      = StRefill;
        end
        if (flush) valid_d = '0;
        flush_pend_d = 1'b0;
      end
      StRefill: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_line_q, cnt_q};
        if (mem_ack_i) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + OFS_W'(1);
          if (cnt_q == LastWord) state_d = StWrite;
        end
        if (flush) flush_pend_d = 1'b1;
      end
      StWrite: begin
        tag_we = 1'b1;
        valid_d[miss_line_q[TAG_LO-1:IDX_LO]] = 1'b1;
        // A flush seen during the refill also drops the line just written.
        if (flush || flush_pend_q) valid_d = '0;
        flush_pend_d = 1'b0;
        state_d      = StLookup;
      end
      default: state_d = StLookup;
    endcase
  end

  // Control state with synchronous reset; a reset mid-refill leaves the line invalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StLookup;
      addr_q       <= '0;
      miss_line_q  <= '0;
      lookup_vld_q <= 1'b0;
      cnt_q        <= '0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_i[30:IDX_LO];
      miss_line_q  <= miss_line_d;
      lookup_vld_q <= lookup_vld_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Synchronous-read data and tag arrays, always read at the fetch address.
  always_ff @(posedge clk_i) begin
    if (data_we) data_mem[{miss_line_q[TAG_LO-1:IDX_LO], cnt_q}] <= mem_data_i;
    if (tag_we) tag_mem[miss_line_q[TAG_LO-1:IDX_LO]] <= miss_line_q[30:TAG_LO];
    data_rd_q <= data_mem[addr_i[TAG_LO-1:2]];
    tag_rd_q  <= tag_mem[addr_i[TAG_LO-1:IDX_LO]];
  end

endmodule
